vga_rx_timing: RTL and testbench

- Receive-side counterpart of the VGA timing generator: consumes hsync/vsync/RGB565 in the generator's format and recovers pixel coordinates and a data-enable.
- Checks line and frame lengths and reports lock to the 640x480@60 timing.
- Used for loopback verification of the generator, and as the front end of a frame-capture path feeding pixel buffers.

---
 rtl/vga_rx_timing.sv | 199 +++++++++++++++++++
 tb/tb_vga_rx_timing.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/vga_rx_timing.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : vga_rx_timing
// Purpose  : Recovers pixel coordinates and data-enable from hsync/vsync/RGB565
//            and tracks lock to the expected line and frame lengths.
// Revision : 1.0 - initial release
// ============================================================================
module vga_rx_timing #(
    parameter int H_SYNC      = 96,
    parameter int H_BACK      = 40,
    parameter int H_LEFT      = 8,
    parameter int H_VALID     = 640,
    parameter int H_TOTAL     = 800,
    parameter int V_SYNC      = 2,
    parameter int V_BACK      = 25,
    parameter int V_TOP       = 8,
    parameter int V_VALID     = 480,
    parameter int V_TOTAL     = 525,
    parameter int LOCK_FRAMES = 2
) (
    input  logic        vga_clk,
    input  logic        sys_rst,
    input  logic        hsync,
    input  logic        vsync,
    input  logic [15:0] rgb_in,
    output logic [9:0]  pix_x,
    output logic [9:0]  pix_y,
    output logic        de,
    output logic [15:0] pix_data,
    output logic        locked,
    output logic        frame_start,
    output logic        line_err,
    output logic        frame_err
);

    localparam logic [10:0] C_H_START = 11'(H_SYNC + H_BACK + H_LEFT);
    localparam logic [10:0] C_H_END   = 11'(H_SYNC + H_BACK + H_LEFT + H_VALID);
    localparam logic [10:0] C_V_START = 11'(V_SYNC + V_BACK + V_TOP);
    localparam logic [10:0] C_V_END   = 11'(V_SYNC + V_BACK + V_TOP + V_VALID);
    localparam logic [10:0] C_H_TOTAL = 11'(H_TOTAL);
    localparam logic [10:0] C_V_TOTAL = 11'(V_TOTAL);
    localparam int          GOOD_W    = (LOCK_FRAMES < 2) ? 1 : $clog2(LOCK_FRAMES + 1);
    localparam logic [GOOD_W-1:0] C_LOCK = GOOD_W'(LOCK_FRAMES);

    typedef enum logic [1:0] {
        ST_SEARCH = 2'd0,
        ST_CHECK  = 2'd1,
        ST_LOCKED = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [GOOD_W-1:0] good_q, good_d;
    logic              hs1_q, hs2_q, vs1_q, vs2_q;
    logic [15:0]       rgb1_q;
    logic [10:0]       h_pos_q, h_pos_d;
    logic [9:0]        v_pos_q, v_pos_d;
    logic              v_pend_q, v_pend_d;
    logic              seen_h_q, seen_h_d, seen_f_q, seen_f_d;
    logic              bad_q, bad_d;
    logic              de_q, de_d;
    logic [9:0]        pix_x_q, pix_x_d, pix_y_q, pix_y_d;
    logic [15:0]       pix_data_q, pix_data_d;
    logic              locked_q, fs_q, lerr_q, ferr_q;

    logic              w_h_rise, w_v_rise, w_fs, w_timeout;
    logic              w_line_err, w_frame_err, w_clean, w_active;
    logic [10:0]       w_v_ext;

    // h_pos_d/v_pos_d are the coordinates of the sample currently in stage 1.
    always_comb begin
        w_h_rise    = hs1_q & ~hs2_q;
        w_v_rise    = vs1_q & ~vs2_q;
        w_fs        = w_h_rise & (v_pend_q | w_v_rise);
        h_pos_d     = w_h_rise ? 11'd0 :
                      ((h_pos_q == 11'h7ff) ? h_pos_q : h_pos_q + 11'd1);
        w_timeout   = (h_pos_d == 11'h7ff);
        v_pos_d     = v_pos_q;
        if (w_h_rise) begin
            v_pos_d = w_fs ? 10'd0 :
                      ((v_pos_q == 10'h3ff) ? v_pos_q : v_pos_q + 10'd1);
        end
        v_pend_d    = w_h_rise ? 1'b0 : (v_pend_q | w_v_rise);
        w_line_err  = w_h_rise & seen_h_q & ((h_pos_q + 11'd1) != C_H_TOTAL);
        w_frame_err = w_fs & seen_f_q & (({1'b0, v_pos_q} + 11'd1) != C_V_TOTAL);
        w_clean     = ~bad_q & ~w_line_err & ~w_frame_err;
        seen_h_d    = w_timeout ? 1'b0 : (seen_h_q | w_h_rise);
        seen_f_d    = w_timeout ? 1'b0 : (seen_f_q | w_fs);
        bad_d       = w_fs ? 1'b0 : (bad_q | w_line_err | w_frame_err);

        w_v_ext     = {1'b0, v_pos_d};
        w_active    = (h_pos_d >= C_H_START) && (h_pos_d < C_H_END) &&
                      (w_v_ext >= C_V_START) && (w_v_ext < C_V_END);
        de_d        = (state_q == ST_LOCKED) & w_active;
        pix_x_d     = de_d ? 10'(h_pos_d - C_H_START) : 10'h3ff;
        pix_y_d     = de_d ? 10'(w_v_ext - C_V_START) : 10'h3ff;
        pix_data_d  = de_d ? rgb1_q : 16'h0;
    end

    always_comb begin
        state_d = state_q;
        good_d  = good_q;
        case (state_q)
            ST_SEARCH: begin
                if (w_fs) begin
                    state_d = ST_CHECK;
                    good_d  = '0;
                end
            end
            ST_CHECK: begin
                if (w_fs) begin
                    if (!w_clean) begin
                        good_d = '0;
                    end else if ((good_q + GOOD_W'(1)) == C_LOCK) begin
                        state_d = ST_LOCKED;
                        good_d  = '0;
                    end else begin
                        good_d = good_q + GOOD_W'(1);
                    end
                end
            end
            ST_LOCKED: begin
                if (w_line_err || w_frame_err) begin
                    state_d = ST_CHECK;
                    good_d  = '0;
                end
            end
            default: begin
                state_d = ST_SEARCH;
                good_d  = '0;
            end
        endcase
        // Lost hsync overrides everything: restart acquisition from scratch.
        if (w_timeout) begin
            state_d = ST_SEARCH;
            good_d  = '0;
        end
    end

    always_ff @(posedge vga_clk) begin
        if (sys_rst) begin
            state_q    <= ST_SEARCH;
            good_q     <= '0;
            hs1_q      <= 1'b0;
            hs2_q      <= 1'b0;
            vs1_q      <= 1'b0;
            vs2_q      <= 1'b0;
            rgb1_q     <= 16'h0;
            h_pos_q    <= 11'd0;
            v_pos_q    <= 10'd0;
            v_pend_q   <= 1'b0;
            seen_h_q   <= 1'b0;
            seen_f_q   <= 1'b0;
            bad_q      <= 1'b0;
            de_q       <= 1'b0;
            pix_x_q    <= 10'h3ff;
            pix_y_q    <= 10'h3ff;
            pix_data_q <= 16'h0;
            locked_q   <= 1'b0;
            fs_q       <= 1'b0;
            lerr_q     <= 1'b0;
            ferr_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            good_q     <= good_d;
            hs1_q      <= hsync;
            hs2_q      <= hs1_q;
            vs1_q      <= vsync;
            vs2_q      <= vs1_q;
            rgb1_q     <= rgb_in;
            h_pos_q    <= h_pos_d;
            v_pos_q    <= v_pos_d;
            v_pend_q   <= v_pend_d;
            seen_h_q   <= seen_h_d;
            seen_f_q   <= seen_f_d;
            bad_q      <= bad_d;
            de_q       <= de_d;
            pix_x_q    <= pix_x_d;
            pix_y_q    <= pix_y_d;
            pix_data_q <= pix_data_d;
            // Uses the pre-update state so locked falls one cycle after an error pulse.
            locked_q   <= (state_q == ST_LOCKED);
            fs_q       <= w_fs & (state_q == ST_LOCKED);
            lerr_q     <= w_line_err;
            ferr_q     <= w_frame_err;
        end
    end

    assign de          = de_q;
    assign pix_x       = pix_x_q;
    assign pix_y       = pix_y_q;
    assign pix_data    = pix_data_q;
    assign locked      = locked_q;
    assign frame_start = fs_q;
    assign line_err    = lerr_q;
    assign frame_err   = ferr_q;

endmodule
`default_nettype wire

// File: tb/tb_vga_rx_timing.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_vga_rx_timing
// Purpose  : Frame-table driven bench for vga_rx_timing on a reduced raster.
// Revision : 1.0 - initial release
// ============================================================================
module tb_vga_rx_timing;

    localparam int HS = 4, HB = 2, HL = 2, HV = 16, HT = 30;
    localparam int VS = 2, VB = 2, VT = 1, VV = 8, VTOT = 16;
    localparam int HSTART = HS + HB + HL;
    localparam int VSTART = VS + VB + VT;
    localparam int FULL   = HV * VV;
    localparam int RST_COL = 12;

    logic        clk = 1'b0;
    logic        sys_rst, hsync, vsync;
    logic [15:0] rgb_in;
    logic [9:0]  pix_x, pix_y;
    logic        de, locked, frame_start, line_err, frame_err;
    logic [15:0] pix_data;

    always #5 clk = ~clk;

    vga_rx_timing #(
        .H_SYNC(HS), .H_BACK(HB), .H_LEFT(HL), .H_VALID(HV), .H_TOTAL(HT),
        .V_SYNC(VS), .V_BACK(VB), .V_TOP(VT), .V_VALID(VV), .V_TOTAL(VTOT),
        .LOCK_FRAMES(2)
    ) dut (
        .vga_clk(clk), .sys_rst(sys_rst), .hsync(hsync), .vsync(vsync),
        .rgb_in(rgb_in), .pix_x(pix_x), .pix_y(pix_y), .de(de),
        .pix_data(pix_data), .locked(locked), .frame_start(frame_start),
        .line_err(line_err), .frame_err(frame_err)
    );

    typedef struct packed {
        logic        act;
        logic [9:0]  x;
        logic [9:0]  y;
        logic [15:0] d;
    } px_t;

    typedef struct {
        int n_lines;
        int short_line;
        int gap;
        int rst_line;
        int exp_de;
        int exp_lerr;
        int exp_ferr;
        int exp_fs;
        int exp_lock;
    } rec_t;

    int   tests = 0;
    int   fails = 0;
    px_t  cur = '0;
    px_t  h1 = '0, h2 = '0;
    int   n_de = 0, n_lerr = 0, n_ferr = 0, n_fs = 0, pixmm = 0;
    int   err_at = 0, err_next = 0;
    bit   prev_err = 1'b0;
    rec_t tbl[$];

    // Reference pixel is the source sample driven two clock edges earlier.
    always @(negedge clk) begin
        if (de) begin
            n_de++;
            if (!h2.act || pix_x != h2.x || pix_y != h2.y || pix_data != h2.d) pixmm++;
        end else if (pix_x != 10'h3ff || pix_y != 10'h3ff || pix_data != 16'h0) begin
            pixmm++;
        end
        if (line_err)    n_lerr++;
        if (frame_err)   n_ferr++;
        if (frame_start) n_fs++;
        if (prev_err) err_next = int'(locked);
        if (line_err || frame_err) err_at = int'(locked);
        prev_err = line_err | frame_err;
        h2 = h1;
        h1 = cur;
    end

    task automatic check(input string name, input int got, input int exp);
        tests++;
        if (got != exp) begin
            fails++;
            $display("FAIL %s got %0d want %0d", name, got, exp);
        end
    endtask

    task automatic drive_idle();
        @(posedge clk); #1;
        sys_rst = 1'b0;
        hsync   = 1'b0;
        vsync   = 1'b0;
        rgb_in  = 16'h1234;
        cur     = '0;
    endtask

    task automatic drive(input int l, input int c, input bit r);
        @(posedge clk); #1;
        sys_rst = r;
        hsync   = (c < HS);
        vsync   = (l < VS);
        cur.act = (l >= VSTART) && (l < VSTART + VV) && (c >= HSTART) && (c < HSTART + HV);
        cur.x   = 10'(c - HSTART);
        cur.y   = 10'(l - VSTART);
        cur.d   = {cur.y[5:0], cur.x};
        rgb_in  = cur.act ? cur.d : 16'(l * 97 + c * 13 + 23130);
    endtask

    task automatic run_rec(input int idx, input rec_t r);
        int  b_de, b_lerr, b_ferr, b_fs, b_mm, len;
        bit  rst_now, rst_chk;
        b_de = n_de; b_lerr = n_lerr; b_ferr = n_ferr; b_fs = n_fs; b_mm = pixmm;
        rst_chk = 1'b0;
        for (int g = 0; g < r.gap; g++) drive_idle();
        if (r.gap > 0) check($sformatf("rec%0d_timeout_locked", idx), int'(locked), 0);
        for (int l = 0; l < r.n_lines; l++) begin
            len = (l == r.short_line) ? HT - 1 : HT;
            for (int c = 0; c < len; c++) begin
                rst_now = (l == r.rst_line) && (c == RST_COL);
                drive(l, c, rst_now);
                if (rst_chk) begin
                    check($sformatf("rec%0d_postrst_de", idx), int'(de), 0);
                    check($sformatf("rec%0d_postrst_x", idx), int'(pix_x), 1023);
                    check($sformatf("rec%0d_postrst_y", idx), int'(pix_y), 1023);
                    check($sformatf("rec%0d_postrst_data", idx), int'(pix_data), 0);
                    check($sformatf("rec%0d_postrst_locked", idx), int'(locked), 0);
                    rst_chk = 1'b0;
                end
                if (rst_now) begin
                    check($sformatf("rec%0d_prerst_locked", idx), int'(locked), 1);
                    rst_chk = 1'b1;
                end
            end
        end
        check($sformatf("rec%0d_de_count", idx), n_de - b_de, r.exp_de);
        check($sformatf("rec%0d_line_err", idx), n_lerr - b_lerr, r.exp_lerr);
        check($sformatf("rec%0d_frame_err", idx), n_ferr - b_ferr, r.exp_ferr);
        check($sformatf("rec%0d_frame_start", idx), n_fs - b_fs, r.exp_fs);
        check($sformatf("rec%0d_locked_end", idx), int'(locked), r.exp_lock);
        check($sformatf("rec%0d_pixel_errs", idx), pixmm - b_mm, 0);
        if (r.exp_lerr + r.exp_ferr > 0) begin
            check($sformatf("rec%0d_locked_at_err", idx), err_at, 1);
            check($sformatf("rec%0d_locked_after_err", idx), err_next, 0);
        end
    endtask

    initial begin
        sys_rst = 1'b1;
        hsync   = 1'b0;
        vsync   = 1'b0;
        rgb_in  = 16'h0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_de", int'(de), 0);
        check("reset_pix_x", int'(pix_x), 1023);
        check("reset_pix_y", int'(pix_y), 1023);
        check("reset_pix_data", int'(pix_data), 0);
        check("reset_locked", int'(locked), 0);
        check("reset_pulses", int'({frame_start, line_err, frame_err}), 0);
        repeat (4) drive_idle();

        //               lines short gap  rst  de          lerr ferr fs lock
        tbl.push_back('{VTOT,   -1,    0,  -1, 0,           0,   0,   0, 0}); // FS1: SEARCH->CHECK
        tbl.push_back('{VTOT,   -1,    0,  -1, 0,           0,   0,   0, 0}); // good=1
        tbl.push_back('{VTOT,   -1,    0,  -1, FULL,        0,   0,   0, 1}); // locks at FS3
        tbl.push_back('{VTOT,   -1,    0,  -1, FULL,        0,   0,   1, 1});
        tbl.push_back('{VTOT,    6,    0,  -1, 2 * HV,      1,   0,   1, 0}); // short line 6
        tbl.push_back('{VTOT,   -1,    0,  -1, 0,           0,   0,   0, 0}); // bad frame ends
        tbl.push_back('{VTOT,   -1,    0,  -1, 0,           0,   0,   0, 0});
        tbl.push_back('{VTOT,   -1,    0,  -1, FULL,        0,   0,   0, 1});
        tbl.push_back('{VTOT-1, -1,    0,  -1, FULL,        0,   0,   1, 1}); // short frame
        tbl.push_back('{VTOT,   -1,    0,  -1, 0,           0,   1,   1, 0}); // frame_err here
        tbl.push_back('{VTOT,   -1,    0,  -1, 0,           0,   0,   0, 0});
        tbl.push_back('{VTOT,   -1,    0,  -1, FULL,        0,   0,   0, 1});
        tbl.push_back('{VTOT,   -1, 2100,  -1, 0,           0,   0,   0, 0}); // hsync timeout
        tbl.push_back('{VTOT,   -1,    0,  -1, 0,           0,   0,   0, 0});
        tbl.push_back('{VTOT,   -1,    0,  -1, FULL,        0,   0,   0, 1});
        tbl.push_back('{VTOT,   -1,    0,   8, 3 * HV + (RST_COL - 2 - HSTART + 1),
                                                            0,   0,   1, 0}); // reset mid-frame
        tbl.push_back('{VTOT,   -1,    0,  -1, 0,           0,   0,   0, 0});
        tbl.push_back('{VTOT,   -1,    0,  -1, 0,           0,   0,   0, 0});
        tbl.push_back('{VTOT,   -1,    0,  -1, FULL,        0,   0,   0, 1});
        tbl.push_back('{VTOT,   -1,    0,  -1, FULL,        0,   0,   1, 1});

        for (int i = 0; i < tbl.size(); i++) run_rec(i, tbl[i]);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
